// File: rtl/cond_unit.sv
// Execute-stage condition unit: holds NZCV, evaluates the instruction condition
// against the stored flags, gates PC/register/memory writes and counts outcomes.
module cond_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Valid,
  input  logic             Flush,
  input  logic [3:0]       Cond,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic [3:0]       ALUFlag,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic             UndefInstr,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
);

  logic [3:0]       flags_q, flags_d;
  logic             undef_q, undef_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic             cond_ok;
  logic             live;
  logic             go;

  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0:    eval_cond = z;
      4'h1:    eval_cond = ~z;
      4'h2:    eval_cond = c;
      4'h3:    eval_cond = ~c;
      4'h4:    eval_cond = n;
      4'h5:    eval_cond = ~n;
      4'h6:    eval_cond = v;
      4'h7:    eval_cond = ~v;
      4'h8:    eval_cond = c & ~z;
      4'h9:    eval_cond = ~c | z;
      4'hA:    eval_cond = (n == v);
      4'hB:    eval_cond = (n != v);
      4'hC:    eval_cond = ~z & (n == v);
      4'hD:    eval_cond = z | (n != v);
      4'hE:    eval_cond = 1'b1;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    sat_inc = (&x) ? x : x + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Condition is judged on flags from earlier instructions, never same-cycle ALUFlag.
  assign cond_ok = eval_cond(Cond, flags_q);
  assign live    = Valid & ~Flush;
  assign go      = live & cond_ok & reset_n;

  assign CondEx     = cond_ok;
  assign PCSrc      = PCS & go;
  assign MemWrite   = MemW & go;
  assign RegWrite   = RegW & go & ~NoWrite;
  assign Flags      = flags_q;
  assign UndefInstr = undef_q;
  assign ExecCount  = exec_q;
  assign SkipCount  = skip_q;

  always_comb begin
    flags_d = flags_q;
    exec_d  = exec_q;
    skip_d  = skip_q;
    undef_d = live & (Cond == 4'hF);
    if (go && FlagW[1]) flags_d[3:2] = ALUFlag[3:2];
    if (go && FlagW[0]) flags_d[1:0] = ALUFlag[1:0];
    if (live) begin
      if (cond_ok) exec_d = sat_inc(exec_q);
      else         skip_d = sat_inc(skip_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
      undef_q <= 1'b0;
      exec_q  <= '0;
      skip_q  <= '0;
    end else begin
      flags_q <= flags_d;
      undef_q <= undef_d;
      exec_q  <= exec_d;
      skip_q  <= skip_d;
    end
  end

endmodule
